// File: rtl/lifegame_pkg.sv
// Shared types and grid geometry for the lifegame core.
// Holds the scheduler state encoding used by lifegame_gen_sched.
// Grid constants are shared with the compute engine and the cell RAM.
package lifegame_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        RUN       = 2'd2,
        SWAP_WAIT = 2'd3
    } sched_state_t;

    localparam int GRID_W      = 80;
    localparam int GRID_H      = 60;
    localparam int CELL_ADDR_W = 13;

endpackage

// File: rtl/lifegame_frame_div.sv
// Frame divider: counts displayed frames while running and raises a trigger.
// Latency: trigger is combinational with the vsync_start that wraps the count.
// No backpressure; a trigger is a single-cycle pulse and is never held.
module lifegame_frame_div #(
    parameter int FRAMES_PER_GEN = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic vsync_start,
    output logic frameTrig
);

    localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_GEN - 1);

    logic [7:0] fcnt;

    assign frameTrig = run & vsync_start & (fcnt == LAST_FRAME);

    // Frame count: held at zero while stopped, wraps on the last frame of a generation
    always_ff @(posedge clk) begin
        if (!rst) begin
            fcnt <= 8'd0;
        end else if (!run) begin
            fcnt <= 8'd0;
        end else if (vsync_start) begin
            if (fcnt == LAST_FRAME) begin
                fcnt <= 8'd0;
            end else begin
                fcnt <= fcnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/lifegame_gen_sched.sv
// Generation scheduler: launches the engine, arbitrates the cell RAM, swaps banks at frame start.
// Latency: eng_start two cycles after a trigger; bank swap visible one cycle after vsync_start.
// VGA fetch always wins the RAM port; the engine holds eng_req until eng_gnt.
module lifegame_gen_sched
    import lifegame_pkg::*;
#(
    parameter int FRAMES_PER_GEN = 30,
    parameter int GEN_CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 step,
    input  logic                 vsync_start,
    input  logic                 vga_req,
    input  logic                 eng_req,
    input  logic                 eng_done,
    input  logic                 clr_ovr,
    output logic                 eng_start,
    output logic                 eng_gnt,
    output logic                 rd_bank,
    output logic [GEN_CNT_W-1:0] gen_count,
    output logic                 busy,
    output logic                 overrun
);

    sched_state_t state;
    sched_state_t nextState;

    logic frameTrig;
    logic trig;
    logic trigAccept;
    logic pending;
    logic doSwap;

    lifegame_frame_div #(
        .FRAMES_PER_GEN(FRAMES_PER_GEN)
    ) u_frame_div (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .vsync_start (vsync_start),
        .frameTrig   (frameTrig)
    );

    // A step and a frame trigger in the same cycle merge into one request
    assign trig = frameTrig | step;

    // A request can only be queued when no generation is in flight, or at the
    // exact frame boundary that retires the current one
    assign trigAccept = (state == IDLE) || ((state == SWAP_WAIT) && vsync_start);

    assign doSwap = (state == SWAP_WAIT) && vsync_start;

    assign eng_gnt = eng_req & ~vga_req & (state == RUN);
    assign busy    = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode; eng_done outside RUN falls through to the default hold
    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (pending)     nextState = START;
            START:                      nextState = RUN;
            RUN:       if (eng_done)    nextState = SWAP_WAIT;
            SWAP_WAIT: if (vsync_start) nextState = IDLE;
            default:                    nextState = IDLE;
        endcase
    end

    // Pending request: a new accepted trigger wins over the consume in IDLE
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending <= 1'b0;
        end else if (trig && trigAccept) begin
            pending <= 1'b1;
        end else if ((state == IDLE) && pending) begin
            pending <= 1'b0;
        end
    end

    // Registered start pulse, high exactly while the FSM sits in START
    always_ff @(posedge clk) begin
        if (!rst) begin
            eng_start <= 1'b0;
        end else begin
            eng_start <= (nextState == START);
        end
    end

    // Bank swap and generation count, only at frame start so the display never tears
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_bank   <= 1'b0;
            gen_count <= '0;
        end else if (doSwap) begin
            rd_bank   <= ~rd_bank;
            gen_count <= gen_count + GEN_CNT_W'(1);
        end
    end

    // Sticky overrun: a dropped trigger beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (trig && !trigAccept) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule
